ifetch_queue: RTL

Instruction fetch stage directly upstream of the main decoder and datapath.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them with their PC to decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the queue and restart fetch at the target.

---
 rtl/ifetch_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential PC fetch over req/ack, a small instruction
// queue toward decode, and redirect handling that flushes and refetches.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pcplus4,
  input  logic        dec_ready
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   tgt;
  logic [PW-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pc_q    [QDEPTH];
  logic [31:0]   instr_q [QDEPTH];
  logic          push, pop;
  logic [31:0]   head_pc_n, head_instr_n;

  // Credit and next queue bookkeeping; a redirect discards everything.
  always_comb begin
    tgt          = redirect_pc & ~32'h3;
    pop          = dec_valid & dec_ready;
    push         = (state == WAIT) & imem_ack & ~redirect;
    cnt_n        = cnt + CW'(push) - CW'(pop);
    head_n       = head + PW'(pop);
    tail_n       = tail + PW'(push);
    head_pc_n    = pc_q[head_n];
    head_instr_n = instr_q[head_n];
    // Entry being written this cycle becomes the head when the queue drains to it.
    if (push && (tail == head_n)) begin
      head_pc_n    = fpc;
      head_instr_n = imem_rdata;
    end
    if (redirect) begin
      cnt_n  = '0;
      head_n = '0;
      tail_n = '0;
    end
  end

  // Fetch state machine with registered request and address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      fpc <= tgt;
      if ((state != IDLE) && !imem_ack) begin
        state    <= DROP;
        imem_req <= 1'b1;
      end else begin
        state     <= IDLE;
        imem_req  <= 1'b0;
        imem_addr <= tgt;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cnt < FULL) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fpc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fpc       <= fpc + 32'd4;
            imem_addr <= fpc + 32'd4;
            if (cnt_n < FULL) begin
              state    <= WAIT;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= fpc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers, occupancy and registered decode-facing head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      dec_valid   <= 1'b0;
      dec_instr   <= '0;
      dec_pc      <= '0;
      dec_pcplus4 <= '0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      cnt       <= cnt_n;
      dec_valid <= (cnt_n != '0);
      if (cnt_n != '0) begin
        dec_instr   <= head_instr_n;
        dec_pc      <= head_pc_n;
        dec_pcplus4 <= head_pc_n + 32'd4;
      end else begin
        dec_instr   <= '0;
        dec_pc      <= '0;
        dec_pcplus4 <= '0;
      end
    end
  end

  // Queue storage; credit flow control must never let a push hit a full queue.
  always_ff @(posedge clk) begin
    if (push) begin
      assert (cnt != FULL);
      pc_q[tail]    <= fpc;
      instr_q[tail] <= imem_rdata;
    end
  end

endmodule
